region_write_arbiter: RTL and testbench

REGION_WRITE_ARBITER -- requirements
Module: region_write_arbiter

---
 rtl/region_write_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_region_write_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/region_write_arbiter.sv
// region_write_arbiter
// Arbitrates NUM_REQ burst write requesters onto one registered region
// write port. Idle requesters are served round-robin; a requester that
// starts a multi-beat burst keeps the region until its last beat, or until
// it has left the lock unused for LOCK_TIMEOUT cycles, in which case the
// lock is broken and the owner is told through a one-cycle abort pulse.
module region_write_arbiter #(
  parameter int WIDTH        = 8,
  parameter int LOG2_DEPTH   = 5,
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*LOG2_DEPTH-1:0] req_waddr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*2-1:0]          req_wfifobram,
  output logic [NUM_REQ-1:0]            ready,
  output logic [NUM_REQ-1:0]            abort,
  input  logic                          almostfull,
  output logic                          we,
  output logic [LOG2_DEPTH-1:0]         waddr,
  output logic [WIDTH-1:0]              wdata,
  output logic [1:0]                    wfifobram,
  output logic [31:0]                   beat_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]       owner_q, owner_d;
  logic [15:0]            idle_cnt_q, idle_cnt_d;
  logic                   we_q, we_d;
  logic [LOG2_DEPTH-1:0]  waddr_q, waddr_d;
  logic [WIDTH-1:0]       wdata_q, wdata_d;
  logic [1:0]             wfifobram_q, wfifobram_d;
  logic [NUM_REQ-1:0]     abort_q, abort_d;
  logic [31:0]            beat_count_q, beat_count_d;

  logic [PTR_W:0]         scan_idx;
  logic [PTR_W-1:0]       pick;
  logic [PTR_W-1:0]       gnt;
  logic                   gnt_ok;
  logic                   accept;
  logic [NUM_REQ-1:0]     ready_c;

  // Round-robin successor of a requester index.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(NUM_REQ - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  // Scanning from the far end down lets the closest hit overwrite the rest.
  always_comb begin
    pick     = '0;
    scan_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (scan_idx >= (PTR_W + 1)'(NUM_REQ)) begin
        scan_idx = scan_idx - (PTR_W + 1)'(NUM_REQ);
      end
      if (req[scan_idx[PTR_W-1:0]]) begin
        pick = scan_idx[PTR_W-1:0];
      end
    end
  end

  // Grant selection: the round-robin pick when idle, the lock owner otherwise.
  always_comb begin
    gnt     = (state_q == IDLE) ? pick : owner_q;
    gnt_ok  = (state_q == IDLE) ? (|req) : req[owner_q];
    accept  = gnt_ok && !almostfull;
    ready_c = '0;
    if (accept) begin
      ready_c[gnt] = 1'b1;
    end
  end

  // Next-state logic for the lock FSM, the write port and the beat counter.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    idle_cnt_d   = idle_cnt_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    wfifobram_d  = wfifobram_q;
    abort_d      = '0;
    beat_count_d = beat_count_q;

    if (accept) begin
      we_d         = 1'b1;
      waddr_d      = req_waddr[gnt*LOG2_DEPTH +: LOG2_DEPTH];
      wdata_d      = req_wdata[gnt*WIDTH +: WIDTH];
      wfifobram_d  = req_wfifobram[gnt*2 +: 2];
      beat_count_d = beat_count_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        idle_cnt_d = '0;
        if (accept) begin
          if (req_last[gnt]) begin
            rr_ptr_d = next_ptr(gnt);
          end else begin
            state_d = LOCKED;
            owner_d = gnt;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          idle_cnt_d = '0;
          if (req_last[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr(owner_q);
          end
        end else if (req[owner_q] || almostfull) begin
          // Owner is still engaged or the region is stalling it: not idle.
          idle_cnt_d = '0;
        end else if (idle_cnt_q == 16'(LOCK_TIMEOUT - 1)) begin
          // This cycle is the LOCK_TIMEOUT-th idle one: break the lock.
          idle_cnt_d       = '0;
          abort_d[owner_q] = 1'b1;
          state_d          = IDLE;
          rr_ptr_d         = next_ptr(owner_q);
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any lock in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      idle_cnt_q   <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      wfifobram_q  <= '0;
      abort_q      <= '0;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      idle_cnt_q   <= idle_cnt_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      wfifobram_q  <= wfifobram_d;
      abort_q      <= abort_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign ready      = reset ? ready_c : '0;
  assign abort      = abort_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign wfifobram  = wfifobram_q;
  assign beat_count = beat_count_q;

endmodule

// File: tb/tb_region_write_arbiter.sv
// Testbench for region_write_arbiter: directed bursts; every expected write
// is queued by the stimulus and popped by an independent write monitor.
module tb_region_write_arbiter;

  localparam int WIDTH        = 8;
  localparam int LOG2_DEPTH   = 5;
  localparam int NUM_REQ      = 2;
  localparam int LOCK_TIMEOUT = 4;
  localparam int EW           = LOG2_DEPTH + WIDTH + 2;

  logic                          clk;
  logic                          reset;
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*LOG2_DEPTH-1:0] req_waddr;
  logic [NUM_REQ*WIDTH-1:0]      req_wdata;
  logic [NUM_REQ*2-1:0]          req_wfifobram;
  logic [NUM_REQ-1:0]            ready;
  logic [NUM_REQ-1:0]            abort;
  logic                          almostfull;
  logic                          we;
  logic [LOG2_DEPTH-1:0]         waddr;
  logic [WIDTH-1:0]              wdata;
  logic [1:0]                    wfifobram;
  logic [31:0]                   beat_count;

  int n_chk  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  region_write_arbiter #(
    .WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH), .NUM_REQ(NUM_REQ), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_last(req_last),
    .req_waddr(req_waddr), .req_wdata(req_wdata), .req_wfifobram(req_wfifobram),
    .ready(ready), .abort(abort), .almostfull(almostfull),
    .we(we), .waddr(waddr), .wdata(wdata), .wfifobram(wfifobram),
    .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hand-chosen beat contents: requester i, beat number b.
  function automatic logic [EW-1:0] beat_val(input int i, input int b);
    logic [LOG2_DEPTH-1:0] a;
    logic [WIDTH-1:0]      d;
    logic [1:0]            f;
    a = LOG2_DEPTH'(i * 16 + b);
    d = WIDTH'(160 + i * 16 + b);
    f = 2'(b + i);
    return {a, d, f};
  endfunction

  task automatic beat(input int i, input int b, input logic last);
    logic [EW-1:0] v;
    v = beat_val(i, b);
    req_waddr[i*LOG2_DEPTH +: LOG2_DEPTH] = v[EW-1 -: LOG2_DEPTH];
    req_wdata[i*WIDTH +: WIDTH]           = v[WIDTH+1:2];
    req_wfifobram[i*2 +: 2]               = v[1:0];
    req_last[i[0]]                        = last;
  endtask

  task automatic push(input int i, input int b);
    exp_q.push_back(beat_val(i, b));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Write monitor: every region write must match the oldest queued beat.
  always @(negedge clk) begin
    if (reset === 1'b1 && we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(we), 32'd0);
      end else begin
        check("write_beat", 32'({waddr, wdata, wfifobram}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; almostfull = 1'b0;
    req = 2'b11; req_last = 2'b11;
    req_waddr = '0; req_wdata = '0; req_wfifobram = '0;

    // Reset state, with requests pending to prove ready is held low
    step(); step();
    #1;
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_beat_count", beat_count, 32'd0);
    check("rst_wport", 32'({waddr, wdata, wfifobram}), 32'd0);
    req = 2'b00;
    step();
    reset = 1'b1;
    #1;
    check("post_rst_we", 32'(we), 32'd0);

    // Both requesters, single-beat bursts: grants alternate 0,1,0,1
    for (int c = 0; c < 4; c++) begin
      step();
      beat(0, c, 1'b1); beat(1, c, 1'b1); req = 2'b11;
      #1;
      check("rr_ready", 32'(ready), (c % 2 == 0) ? 32'd1 : 32'd2);
      push(c % 2, c);
    end
    step();
    req = 2'b00;
    #1;
    check("rr_beat_count", beat_count, 32'd4);

    // Reset in the middle of a burst from requester 0 (beat_count reaches 7)
    for (int b = 0; b < 3; b++) begin
      step();
      beat(0, 8 + b, 1'b0); req = 2'b01;
      #1;
      check("burst0_ready", 32'(ready), 32'd1);
      // the third beat's write is wiped by the reset before it is seen
      if (b < 2) push(0, 8 + b);
    end
    step();
    check("pre_rst_count", beat_count, 32'd7);
    reset = 1'b0;
    #1;
    check("midrst_we", 32'(we), 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_count", beat_count, 32'd0);
    check("midrst_wport", 32'({waddr, wdata, wfifobram}), 32'd0);
    beat(0, 12, 1'b1); beat(1, 12, 1'b1); req = 2'b11;
    step(); step();
    reset = 1'b1;
    #1;
    check("rel_ready", 32'(ready), 32'd1);
    check("rel_we", 32'(we), 32'd0);
    push(0, 12);
    step();
    req = 2'b00;
    #1;
    check("rel_count", beat_count, 32'd1);

    // Requester 1 holds a 3-beat burst while requester 0 waits
    step();
    beat(1, 0, 1'b0); req = 2'b10;
    #1; check("lock1_b0_ready", 32'(ready), 32'd2); push(1, 0);
    step();
    beat(1, 1, 1'b0); beat(0, 0, 1'b1); req = 2'b11;
    #1; check("lock1_b1_ready", 32'(ready), 32'd2); push(1, 1);
    step();
    beat(1, 2, 1'b1);
    #1; check("lock1_b2_ready", 32'(ready), 32'd2); push(1, 2);
    step();
    req = 2'b01;
    #1; check("after_lock_ready", 32'(ready), 32'd1); push(0, 0);
    step();
    req = 2'b00;

    // Owner 0 goes quiet after a non-last beat: lock timeout
    step();
    beat(0, 1, 1'b0); req = 2'b01;
    #1; check("to_start_ready", 32'(ready), 32'd1); push(0, 1);
    step();
    beat(1, 3, 1'b1); req = 2'b10;
    #1;
    check("to_wait_ready", 32'(ready), 32'd0);
    check("to_wait_abort", 32'(abort), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      step();
      check("to_wait_ready", 32'(ready), 32'd0);
      check("to_wait_abort", 32'(abort), 32'd0);
    end
    step();
    check("to_abort", 32'(abort), 32'd1);
    check("to_ready1", 32'(ready), 32'd2);
    push(1, 3);
    step();
    req = 2'b00;
    #1; check("to_abort_clear", 32'(abort), 32'd0);

    // almostfull stalls a burst owned by requester 1 for 10 cycles
    step();
    beat(1, 4, 1'b0); req = 2'b10;
    #1; check("af_start_ready", 32'(ready), 32'd2); push(1, 4);
    step();
    almostfull = 1'b1; beat(0, 4, 1'b1); req = 2'b01;
    #1; check("af_ready", 32'(ready), 32'd0);
    for (int k = 1; k < 10; k++) begin
      step();
      if (k == 5) begin beat(1, 5, 1'b1); req = 2'b11; end
      #1;
      check("af_ready", 32'(ready), 32'd0);
      check("af_abort", 32'(abort), 32'd0);
      check("af_we", 32'(we), 32'd0);
    end
    step();
    almostfull = 1'b0;
    #1; check("af_resume_owner", 32'(ready), 32'd2); push(1, 5);
    step();
    req = 2'b01;
    #1; check("af_then_req0", 32'(ready), 32'd1); push(0, 4);
    step();
    req = 2'b00;
    #1; check("af_count", beat_count, 32'd10);

    // beat_count wrap from a preloaded value
    force dut.beat_count_q = 32'hFFFF_FFFF;
    step();
    release dut.beat_count_q;
    #1; check("wrap_preload", beat_count, 32'hFFFF_FFFF);
    beat(0, 6, 1'b1); req = 2'b01;
    #1; check("wrap_ready_a", 32'(ready), 32'd1); push(0, 6);
    step();
    beat(0, 7, 1'b1);
    #1;
    check("wrap_zero", beat_count, 32'd0);
    check("wrap_ready_b", 32'(ready), 32'd1);
    push(0, 7);
    step();
    req = 2'b00;
    #1; check("wrap_one", beat_count, 32'd1);

    step(); step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
